sequence_transmitter: RTL and testbench
=======================================

// Module: sequence_transmitter
// PURPOSE
//   Serial bit-stream generator; transmit-side counterpart of the word detector.
//   Buffers WIDTH-bit words in a small FIFO. On start, emits prefix_len
//   pseudo-random filler bits (LFSR), then one word MSB-first, one bit per clk.
//   Feeds the detector's bit_in in system tests and drives serial links.
// PARAMETERS
//   WIDTH       8      word width, bits serialized per word
//   FIFO_DEPTH  4      word buffer entries (power of 2, >=2)
//   LFSR_SEED   8'hA5  filler LFSR reset/seed value (must be non-zero)
// PORTS
//   clk         in   1                   clock, rising edge
//   rst_n       in   1                   reset, asynchronous, active-low
//   load_word   in   1                   push word into FIFO (when load_ready)
//   word        in   WIDTH               word to push
//   load_ready  out  1                   FIFO not full
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered
//   prefix_len  in   4                   filler bits before the word (0..15)
//   start       in   1                   begin one transmission (1-cycle pulse)
//   bit_out     out  1                   serial data
//   bit_valid   out  1                   bit_out carries a stream bit
//   busy        out  1                   transmission in progress
//   done        out  1                   1-cycle pulse after last bit
// BEHAVIOUR
//   Reset: FIFO empty, fifo_count=0, load_ready=1, bit_out=0, bit_valid=0,
//     busy=0, done=0, FSM=IDLE, LFSR=LFSR_SEED. Applies immediately, including
//     mid-transmission; the partial stream is abandoned, no done pulse.
//   FIFO: push on load_word&&load_ready; push when full is dropped, count and
//     contents unchanged. Pop only on accepted start. Push+pop in the same
//     cycle: count unchanged, both take effect. load_ready = count<FIFO_DEPTH
//     (registered from count; no same-cycle full bypass).
//   FSM IDLE -> PREFIX -> WORD -> DONE -> IDLE.
//   IDLE: start accepted only if count>0. On accept: pop head word into shift
//     reg, latch prefix_len. Go to PREFIX if latched len>0, else WORD.
//     start with FIFO empty, or start outside IDLE: ignored, no side effects.
//   PREFIX: bit_valid=1, bit_out=LFSR[7]. LFSR advances each PREFIX cycle
//     (Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0).
//     The LFSR holds in all other states and is not reseeded between words.
//     After exactly prefix_len cycles -> WORD.
//   WORD: bit_valid=1, bit_out=shift[WIDTH-1], shift<<=1 each cycle; after
//     exactly WIDTH cycles -> DONE.
//   DONE: done=1 for one cycle, bit_valid=0 -> IDLE. Next start accepted
//     from the IDLE cycle onward.
//   Outputs registered. Start accepted at edge k: first valid bit at k+1.
//     bit_valid is high for exactly prefix_len+WIDTH consecutive cycles.
//   busy=1 in PREFIX, WORD and DONE. bit_out=0 whenever bit_valid=0.
//   Changes to prefix_len or word after acceptance do not affect the stream.
// TESTING
//   1) push 8'hB5, prefix_len=0, start -> next 8 cycles bit_valid=1,
//      bit_out=1,0,1,1,0,1,0,1; then done for 1 cycle; fifo_count 1->0.
//   2) push 8'h3C, prefix_len=3, start -> 3 filler bits = first 3 LFSR
//      outputs from 8'hA5, then 0,0,1,1,1,1,0,0; 11 valid cycles total.
//   3) push 5 words with start idle -> 5th dropped, load_ready=0 at count=4;
//      4 starts emit words 1-4 in order, 5th start ignored.
//   4) start with FIFO empty, and start asserted mid-WORD -> no pop, no change
//      to the stream, no extra done.
//   5) Deassert rst_n in the 4th WORD bit -> all outputs at reset values
//      asynchronously; after release, FIFO empty, LFSR=8'hA5.
//   6) Loop output into detector programmed with 8'hB5, prefix 5 -> detector
//      flags within 1 cycle of the 8th word bit.

Source files
------------

// File: rtl/sequence_transmitter.sv
// ----------------------------------------------------------------------------
// sequence_transmitter
//   Serial bit-stream generator. WIDTH-bit words are buffered in a small FIFO.
//   An accepted start pops one word, emits prefix_len pseudo-random filler
//   bits from an 8-bit Fibonacci LFSR, then the word MSB-first, one bit per
//   clock, followed by a one-cycle done pulse.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_word   in   push word into the FIFO (taken only when load_ready)
//   word        in   WIDTH-bit word to push
//   load_ready  out  FIFO not full (registered from the occupancy count)
//   fifo_count  out  number of buffered words
//   prefix_len  in   filler bits ahead of the word (0..15), latched on start
//   start       in   begin one transmission (ignored unless IDLE and non-empty)
//   bit_out     out  serial data, 0 whenever bit_valid is low
//   bit_valid   out  bit_out carries a stream bit
//   busy        out  transmission in progress (PREFIX, WORD, DONE)
//   done        out  one-cycle pulse after the last stream bit
// ----------------------------------------------------------------------------
module sequence_transmitter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_word,
   input  logic [WIDTH-1:0]              word,
   output logic                          load_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   input  logic [3:0]                    prefix_len,
   input  logic                          start,
   output logic                          bit_out,
   output logic                          bit_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned CNTW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0] BIT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREFIX,
      S_WORD,
      S_DONE
   } state_t;

   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   state_t           state_q,      state_d;
   logic [7:0]       lfsr_q,       lfsr_d;
   logic [WIDTH-1:0] shift_q,      shift_d;
   logic [CNTW-1:0]  bits_q,       bits_d;
   logic [PW-1:0]    wr_ptr_q,     wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q,     rd_ptr_d;
   logic [CW-1:0]    count_q,      count_d;
   logic             load_ready_q, load_ready_d;
   logic             bit_out_q,    bit_out_d;
   logic             bit_valid_q,  bit_valid_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;

   logic             push;
   logic             accept;
   logic [WIDTH-1:0] head;
   logic [7:0]       lfsr_adv;

   assign push     = load_word && load_ready_q;
   assign accept   = (state_q == S_IDLE) && start && (count_q != '0);
   assign head     = mem[rd_ptr_q];
   // taps x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3, shifted in at bit 0
   assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      shift_d      = shift_q;
      bits_d       = bits_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      bit_out_d    = bit_out_q;
      bit_valid_d  = bit_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (accept) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !accept) begin
         count_d = count_q + CNT_ONE;
      end else if (!push && accept) begin
         count_d = count_q - CNT_ONE;
      end
      load_ready_d = (count_d < CNT_FULL);

      // Outputs are computed for the state being entered, so bits_q counts
      // the stream bits still to follow the one currently on bit_out.
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               busy_d      = 1'b1;
               bit_valid_d = 1'b1;
               if (prefix_len != '0) begin
                  state_d   = S_PREFIX;
                  bit_out_d = lfsr_q[7];
                  lfsr_d    = lfsr_adv;
                  shift_d   = head;
                  bits_d    = CNTW'(prefix_len) - BIT_ONE;
               end else begin
                  state_d   = S_WORD;
                  bit_out_d = head[WIDTH-1];
                  shift_d   = {head[WIDTH-2:0], 1'b0};
                  bits_d    = BIT_LAST;
               end
            end
         end
         S_PREFIX: begin
            if (bits_q != '0) begin
               bit_out_d = lfsr_q[7];
               lfsr_d    = lfsr_adv;
               bits_d    = bits_q - BIT_ONE;
            end else begin
               state_d   = S_WORD;
               bit_out_d = shift_q[WIDTH-1];
               shift_d   = {shift_q[WIDTH-2:0], 1'b0};
               bits_d    = BIT_LAST;
            end
         end
         S_WORD: begin
            if (bits_q != '0) begin
               bit_out_d = shift_q[WIDTH-1];
               shift_d   = {shift_q[WIDTH-2:0], 1'b0};
               bits_d    = bits_q - BIT_ONE;
            end else begin
               state_d     = S_DONE;
               bit_out_d   = 1'b0;
               bit_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d     = S_IDLE;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         shift_q      <= '0;
         bits_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         load_ready_q <= 1'b1;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         shift_q      <= shift_d;
         bits_q       <= bits_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         load_ready_q <= load_ready_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= word;
      end
   end

   assign load_ready = load_ready_q;
   assign fifo_count = count_q;
   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sequence_transmitter.sv
// ----------------------------------------------------------------------------
// tb_sequence_transmitter
//   Directed bench for sequence_transmitter (WIDTH=8, FIFO_DEPTH=4, seed A5).
//   Includes a small behavioural word detector looped onto the serial output.
// ----------------------------------------------------------------------------
module tb_sequence_transmitter;

   logic       clk;
   logic       rst_n;
   logic       load_word;
   logic [7:0] word;
   logic       load_ready;
   logic [2:0] fifo_count;
   logic [3:0] prefix_len;
   logic       start;
   logic       bit_out;
   logic       bit_valid;
   logic       busy;
   logic       done;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   sequence_transmitter #(
      .WIDTH      (8),
      .FIFO_DEPTH (4),
      .LFSR_SEED  (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_word  (load_word),
      .word       (word),
      .load_ready (load_ready),
      .fifo_count (fifo_count),
      .prefix_len (prefix_len),
      .start      (start),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector: last 8 valid bits compared with 8'hB5, flag registered.
   logic [7:0] det_sr;
   logic       det_hit;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det_sr  <= '0;
         det_hit <= 1'b0;
      end else begin
         det_hit <= bit_valid && ({det_sr[6:0], bit_out} == 8'hB5);
         if (bit_valid) det_sr <= {det_sr[6:0], bit_out};
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] w);
      load_word = 1'b1;
      word      = w;
      tick();
      load_word = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", load_ready); end
      n_cmp++; if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL reset_outs got %b want 0000", {bit_out, bit_valid, busy, done}); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_word;
      logic [7:0] exp_w;
      exp_w = 8'hB5;
      push_one(8'hB5);
      n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL basic_count_push got %0d want 1", fifo_count); end
      prefix_len = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL basic_count_pop got %0d want 0", fifo_count); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if ({bit_valid, bit_out} !== {1'b1, exp_w[7-i]}) begin n_err++; $display("FAIL basic_bit%0d got v%b d%b want v1 d%b", i, bit_valid, bit_out, exp_w[7-i]); end
         tick();
      end
      n_cmp++; if ({done, busy, bit_valid, bit_out} !== 4'b1100) begin n_err++; $display("FAIL basic_done got %b want 1100", {done, busy, bit_valid, bit_out}); end
      tick();
      n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL basic_idle got %b want 00", {done, busy}); end
   endtask

   task automatic test_prefix;
      logic [10:0] exp_s;
      // filler from seed A5: 1,0,1 ; then 3C
      exp_s = {3'b101, 8'h3C};
      push_one(8'h3C);
      prefix_len = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      prefix_len = 4'd9;
      for (int i = 0; i < 11; i++) begin
         n_cmp++; if ({bit_valid, bit_out, busy} !== {1'b1, exp_s[10-i], 1'b1}) begin n_err++; $display("FAIL prefix_bit%0d got v%b d%b want v1 d%b", i, bit_valid, bit_out, exp_s[10-i]); end
         tick();
      end
      n_cmp++; if ({done, bit_valid} !== 2'b10) begin n_err++; $display("FAIL prefix_done got %b want 10", {done, bit_valid}); end
      tick();
      prefix_len = 4'd0;
   endtask

   task automatic test_fifo_full;
      logic [7:0] words [5];
      logic [7:0] w;
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      load_word = 1'b1;
      for (int i = 0; i < 5; i++) begin
         word = words[i];
         tick();
         n_cmp++; if (fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin n_err++; $display("FAIL full_count%0d got %0d want %0d", i, fifo_count, (i < 4) ? i + 1 : 4); end
         n_cmp++; if (load_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL full_ready%0d got %b want %b", i, load_ready, (i < 3) ? 1'b1 : 1'b0); end
      end
      load_word = 1'b0;
      prefix_len = 4'd0;
      for (int k = 0; k < 4; k++) begin
         w = words[k];
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int i = 0; i < 8; i++) begin
            n_cmp++; if ({bit_valid, bit_out} !== {1'b1, w[7-i]}) begin n_err++; $display("FAIL order_w%0d_bit%0d got v%b d%b want v1 d%b", k, i, bit_valid, bit_out, w[7-i]); end
            tick();
         end
         n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL order_done%0d got %b want 1", k, done); end
         tick();
      end
      n_cmp++; if ({fifo_count, load_ready} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL drained got cnt%0d rdy%b want cnt0 rdy1", fifo_count, load_ready); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if ({busy, bit_valid, fifo_count} !== {2'b00, 3'd0}) begin n_err++; $display("FAIL fifth_start got busy%b v%b cnt%0d want 0 0 0", busy, bit_valid, fifo_count); end
      tick();
   endtask

   task automatic test_ignored_start;
      logic [7:0] w;
      w = 8'hA6;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if ({busy, bit_valid, done} !== 3'b000) begin n_err++; $display("FAIL empty_start got %b want 000", {busy, bit_valid, done}); end
      push_one(8'hA6);
      push_one(8'h0F);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if ({bit_valid, bit_out} !== {1'b1, w[7-i]}) begin n_err++; $display("FAIL midstart_bit%0d got v%b d%b want v1 d%b", i, bit_valid, bit_out, w[7-i]); end
         start = (i == 3);
         tick();
      end
      start = 1'b0;
      n_cmp++; if ({done, fifo_count} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL midstart_done got done%b cnt%0d want done1 cnt1", done, fifo_count); end
      tick();
      n_cmp++; if ({done, busy, bit_valid, fifo_count} !== {3'b000, 3'd1}) begin n_err++; $display("FAIL midstart_after got %b cnt%0d want 000 cnt1", {done, busy, bit_valid}, fifo_count); end
   endtask

   task automatic test_async_reset;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if ({bit_valid, bit_out, fifo_count} !== {2'b10, 3'd0}) begin n_err++; $display("FAIL rst_bit0 got v%b d%b cnt%0d want v1 d0 cnt0", bit_valid, bit_out, fifo_count); end
      load_word = 1'b1;
      word = 8'h77;
      tick();
      load_word = 1'b0;
      n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL rst_refill got %0d want 1", fifo_count); end
      tick();
      tick();
      n_cmp++; if ({bit_valid, busy} !== 2'b11) begin n_err++; $display("FAIL rst_bit3 got %b want 11", {bit_valid, busy}); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin n_err++; $display("FAIL rst_async_outs got %b want 0000", {bit_out, bit_valid, busy, done}); end
      n_cmp++; if ({fifo_count, load_ready} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL rst_async_fifo got cnt%0d rdy%b want cnt0 rdy1", fifo_count, load_ready); end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if ({done, busy, bit_valid, fifo_count} !== {3'b000, 3'd0}) begin n_err++; $display("FAIL rst_after%0d got %b cnt%0d want 000 cnt0", i, {done, busy, bit_valid}, fifo_count); end
      end
   endtask

   task automatic test_detector_loop;
      logic [12:0] exp_s;
      // filler from reseeded A5: 1,0,1,0,0 ; then B5
      exp_s = {5'b10100, 8'hB5};
      push_one(8'hB5);
      prefix_len = 4'd5;
      start = 1'b1;
      load_word = 1'b1;
      word = 8'h5A;
      tick();
      start = 1'b0;
      load_word = 1'b0;
      word = 8'h00;
      prefix_len = 4'd0;
      n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL pushpop_count got %0d want 1", fifo_count); end
      for (int i = 0; i < 13; i++) begin
         n_cmp++; if ({bit_valid, bit_out} !== {1'b1, exp_s[12-i]}) begin n_err++; $display("FAIL loop_bit%0d got v%b d%b want v1 d%b", i, bit_valid, bit_out, exp_s[12-i]); end
         tick();
      end
      n_cmp++; if ({done, det_hit} !== 2'b11) begin n_err++; $display("FAIL loop_detect got done%b hit%b want 1 1", done, det_hit); end
      tick();
   endtask

   initial begin
      load_word  = 1'b0;
      word       = '0;
      prefix_len = '0;
      start      = 1'b0;
      rst_n      = 1'b1;
      test_reset();
      test_basic_word();
      test_prefix();
      test_fifo_full();
      test_ignored_start();
      test_async_reset();
      test_detector_loop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
